// File: rtl/axis_packetizer_if.sv
// AXI-Stream style handshake bundle used on both sides of the packetizer.
// The slave view carries no tlast because the input stream is unframed.
interface axis_packetizer_if #(
    parameter int unsigned DW = 16
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_packetizer.sv
// Cuts an unframed word stream into packets of one header word plus cfg_len payload
// words, driving a registered single-slot AXI-Stream master output.
module axis_packetizer #(
    parameter int unsigned DW      = 16,
    parameter int unsigned LW      = 12,
    parameter logic [3:0]  HDR_TAG = 4'hA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LW-1:0]     cfg_len,
    axis_packetizer_if.slave  s_axis,
    axis_packetizer_if.master m_axis,
    output logic [15:0]       pkt_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [DW-5:0]   seq_q, seq_d;
    logic [15:0]     pkt_q, pkt_d;
    logic [DW-1:0]   tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic            slot_free_s;
    logic            s_tready_s;

    // The slot may be reloaded in the same cycle its current word is taken.
    assign slot_free_s = !tvalid_q || m_axis.tready;
    assign s_tready_s  = (state_q == PAY) && slot_free_s;

    assign s_axis.tready = s_tready_s;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign pkt_count     = pkt_q;
    assign busy          = (state_q != IDLE);

    // Next-state, output-slot and counter computation.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rem_d    = rem_q;
        seq_d    = seq_q;
        pkt_d    = pkt_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (slot_free_s) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
        case (state_q)
            IDLE: begin
                if (s_axis.tvalid) begin
                    len_d   = (cfg_len == LW'(0)) ? LW'(1) : cfg_len;
                    state_d = HDR;
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                if (slot_free_s) begin
                    tdata_d  = {HDR_TAG, seq_q};
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b1;
                    rem_d    = len_q;
                    state_d  = PAY;
                end else begin
                    state_d = HDR;
                end
            end
            PAY: begin
                if (s_axis.tvalid && s_tready_s) begin
                    tdata_d  = s_axis.tdata;
                    tvalid_d = 1'b1;
                    tlast_d  = (rem_q == LW'(1));
                    rem_d    = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        seq_d   = seq_q + (DW-4)'(1);
                        pkt_d   = pkt_q + 16'd1;
                        state_d = IDLE;
                    end else begin
                        state_d = PAY;
                    end
                end else begin
                    state_d = PAY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output register; reset drops any partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            rem_q    <= '0;
            seq_q    <= '0;
            pkt_q    <= 16'd0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            seq_q    <= seq_d;
            pkt_q    <= pkt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: framing, zero length, stalls, length change,
// mid-packet reset and sequence wrap.
module tb_axis_packetizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] cfg_len = 12'd0;
    logic [15:0] pkt_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [16:0] out_q[$];
    logic [15:0] next_in = 16'd0;
    int          in_left = 0;
    int          cyc = 0;
    int          first_valid = -1;
    int          stab_viol = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'd0;
    logic        prev_last = 1'b0;

    axis_packetizer_if #(.DW(16)) s_if ();
    axis_packetizer_if #(.DW(16)) m_if ();

    assign s_if.tlast = 1'b0;

    axis_packetizer #(.DW(16), .LW(12), .HDR_TAG(4'hA)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_len  (cfg_len),
        .s_axis   (s_if.slave),
        .m_axis   (m_if.master),
        .pkt_count(pkt_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: drive at negedge, observe 1 time unit later.
    task automatic cycle(input logic want_sv, input logic mr);
        @(negedge clk);
        s_if.tvalid = want_sv && (in_left > 0);
        s_if.tdata  = next_in;
        m_if.tready = mr;
        #1;
        if (prev_stall && (m_if.tdata !== prev_data || m_if.tlast !== prev_last || m_if.tvalid !== 1'b1))
            stab_viol++;
        if (m_if.tvalid && !m_if.tready && s_if.tready)
            stab_viol++;
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_data  = m_if.tdata;
        prev_last  = m_if.tlast;
        if (s_if.tvalid && s_if.tready) begin
            next_in = next_in + 16'd1;
            in_left = in_left - 1;
        end
        if (m_if.tvalid && m_if.tready) out_q.push_back({m_if.tlast, m_if.tdata});
        if (m_if.tvalid && first_valid < 0) first_valid = cyc;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_stall = 1'b0;
        in_left = 0;
        out_q.delete();
    endtask

    task automatic run_until(input int n, input int budget, input logic rnd, input string name);
        int k;
        k = 0;
        while (out_q.size() < n && k < budget) begin
            cycle(1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            k++;
        end
        if (out_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d words, required %0d", name, out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        s_if.tvalid = 1'b0;
        s_if.tdata  = 16'd0;
        m_if.tready = 1'b1;
        rst_n = 1'b0;
        #12;
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_if.tvalid); end
        checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_if.tlast); end
        checks++; if (m_if.tdata !== 16'h0000) begin errors++; $display("FAIL rst_tdata got %h want 0000", m_if.tdata); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_sready got %b want 0", s_if.tready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt got %0d want 0", pkt_count); end
        do_reset();
    endtask

    task automatic test_basic();
        logic [16:0] exp_w [10];
        exp_w = '{17'h0A000, 17'h00001, 17'h00002, 17'h00003, 17'h10004,
                  17'h0A001, 17'h00005, 17'h00006, 17'h00007, 17'h10008};
        cfg_len = 12'd4;
        next_in = 16'd1;
        in_left = 8;
        cyc = 0;
        first_valid = -1;
        out_q.delete();
        run_until(10, 200, 1'b0, "basic");
        for (int i = 0; i < 10 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL basic_word%0d got %h want %h", i, out_q[i], exp_w[i]);
            end
        end
        checks++; if (first_valid !== 2) begin errors++; $display("FAIL hdr_latency got %0d want 2", first_valid); end
        repeat (3) cycle(1'b0, 1'b1);
        checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL basic_pkt got %0d want 2", pkt_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy); end
    endtask

    task automatic test_len0();
        logic [16:0] exp_w [6];
        exp_w = '{17'h0A002, 17'h10009, 17'h0A003, 17'h1000A, 17'h0A004, 17'h1000B};
        cfg_len = 12'd0;
        in_left = 3;
        out_q.delete();
        run_until(6, 100, 1'b0, "len0");
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL len0_word%0d got %h want %h", i, out_q[i], exp_w[i]);
            end
        end
        repeat (3) cycle(1'b0, 1'b1);
        checks++; if (pkt_count !== 16'd5) begin errors++; $display("FAIL len0_pkt got %0d want 5", pkt_count); end
    endtask

    task automatic test_random_stall();
        logic [16:0] e;
        int p;
        int k;
        do_reset();
        cfg_len = 12'd7;
        next_in = 16'd100;
        in_left = 140;
        stab_viol = 0;
        run_until(160, 3000, 1'b1, "stall");
        for (int i = 0; i < 160 && i < out_q.size(); i++) begin
            p = i / 8;
            k = i % 8;
            if (k == 0) e = {1'b0, 4'hA, 12'(p)};
            else        e = {(k == 7), 16'(100 + p * 7 + k - 1)};
            checks++;
            if (out_q[i] !== e) begin
                errors++;
                $display("FAIL stall_word%0d got %h want %h", i, out_q[i], e);
            end
        end
        repeat (3) cycle(1'b0, 1'b1);
        checks++; if (stab_viol !== 0) begin errors++; $display("FAIL stall_stable got %0d violations want 0", stab_viol); end
        checks++; if (pkt_count !== 16'd20) begin errors++; $display("FAIL stall_pkt got %0d want 20", pkt_count); end
    endtask

    task automatic test_len_change();
        logic [16:0] exp_w [8];
        logic changed;
        int k;
        exp_w = '{17'h0A014, 17'h000C8, 17'h000C9, 17'h000CA, 17'h100CB,
                  17'h0A015, 17'h000CC, 17'h100CD};
        cfg_len = 12'd4;
        next_in = 16'd200;
        in_left = 6;
        changed = 1'b0;
        k = 0;
        out_q.delete();
        while (out_q.size() < 8 && k < 200) begin
            cycle(1'b1, 1'b1);
            if (!changed && in_left == 4) begin
                cfg_len = 12'd2;
                changed = 1'b1;
            end
            k++;
        end
        checks++; if (out_q.size() !== 8) begin errors++; $display("FAIL lchg_count got %0d want 8", out_q.size()); end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL lchg_word%0d got %h want %h", i, out_q[i], exp_w[i]);
            end
        end
        repeat (3) cycle(1'b0, 1'b1);
        checks++; if (pkt_count !== 16'd22) begin errors++; $display("FAIL lchg_pkt got %0d want 22", pkt_count); end
    endtask

    task automatic test_reset_mid();
        cfg_len = 12'd4;
        next_in = 16'd300;
        in_left = 4;
        out_q.delete();
        run_until(3, 100, 1'b0, "rmid_pre");
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid got %b want 0", m_if.tvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rmid_pkt got %0d want 0", pkt_count); end
        @(negedge clk);
        rst_n = 1'b1;
        s_if.tvalid = 1'b0;
        prev_stall = 1'b0;
        cfg_len = 12'd1;
        next_in = 16'd400;
        in_left = 1;
        out_q.delete();
        run_until(2, 100, 1'b0, "rmid_post");
        checks++; if (out_q.size() > 0 && out_q[0] !== 17'h0A000) begin errors++; $display("FAIL rmid_hdr got %h want 0a000", out_q[0]); end
        checks++; if (out_q.size() > 1 && out_q[1] !== 17'h10190) begin errors++; $display("FAIL rmid_pay got %h want 10190", out_q[1]); end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        cfg_len = 12'd1;
        next_in = 16'd0;
        in_left = 4097;
        run_until(8194, 14000, 1'b0, "wrap");
        if (out_q.size() >= 8194) begin
            checks++; if (out_q[8190] !== 17'h0AFFF) begin errors++; $display("FAIL wrap_hdr4095 got %h want 0afff", out_q[8190]); end
            checks++; if (out_q[8192] !== 17'h0A000) begin errors++; $display("FAIL wrap_hdr4096 got %h want 0a000", out_q[8192]); end
            checks++; if (out_q[8193] !== 17'h11000) begin errors++; $display("FAIL wrap_pay got %h want 11000", out_q[8193]); end
        end
        repeat (3) cycle(1'b0, 1'b1);
        checks++; if (pkt_count !== 16'd4097) begin errors++; $display("FAIL wrap_pkt got %0d want 4097", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_random_stall();
        test_len_change();
        test_reset_mid();
        test_seq_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_packetizer.md
Name: axis_packetizer

Overview:
- Framing stage that sits directly upstream of the two-stage AXI-Stream FIFO chain.
- Takes an unframed word stream (no tlast) and cuts it into packets.
- Each packet is one header word followed by cfg_len payload words. tlast is asserted on the final payload word.
- The output is a registered AXI-Stream master that drives the FIFO chain's slave port.

Parameters:
- DW, 16, data width of input/output words; must be >= 8.
- LW, 12, width of the packet length field cfg_len.
- HDR_TAG, 4'hA, constant tag placed in header bits [DW-1:DW-4].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_len  input  LW  payload words per packet; sampled at packet start.
- s_tdata  input  DW  raw input word.
- s_tvalid  input  1  input word valid.
- s_tready  output  1  block accepts input word this cycle.
- m_tdata  output  DW  header or payload word (registered).
- m_tvalid  output  1  output word valid (registered).
- m_tlast  output  1  last payload word of packet (registered).
- m_tready  input  1  downstream ready.
- pkt_count  output  16  number of completed packets, wraps at 16'hFFFF -> 0.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous)
  - FSM = IDLE; m_tvalid = 0, m_tlast = 0, m_tdata = 0.
  - s_tready = 0, seq = 0, pkt_count = 0, busy = 0.
  - Deassertion is synchronised by the surrounding design. Reset mid-packet discards the partial packet; no tlast is emitted for it.
- Output register
  - Single slot. The slot is free when !m_tvalid || m_tready.
  - Loading a new word in a cycle where the old word is handshaked is allowed, giving full throughput.
  - m_tdata, m_tlast and m_tvalid must hold stable while m_tvalid && !m_tready.
- FSM states: IDLE, HDR, PAY.
  - IDLE:
    - s_tready = 0.
    - When s_tvalid = 1: latch len_q = (cfg_len == 0) ? 1 : cfg_len; go to HDR.
    - No input word is consumed in IDLE.
  - HDR:
    - s_tready = 0.
    - When the slot is free: load m_tdata = {HDR_TAG, seq[DW-5:0]}, m_tlast = 0, m_tvalid = 1; set remaining counter = len_q; go to PAY.
  - PAY:
    - s_tready = slot free.
    - On s_tvalid && s_tready: load m_tdata = s_tdata, m_tvalid = 1, m_tlast = (remaining == 1); decrement remaining.
    - If remaining was 1: seq <= seq + 1 (wraps modulo 2^(DW-4)), pkt_count <= pkt_count + 1, go to IDLE.
  - When the slot frees and no word is loaded that cycle, m_tvalid <= 0.
- Latency
  - Header m_tvalid rises 2 cycles after s_tvalid first asserts in IDLE, provided the output path is free.
  - Payload: 1 cycle from input handshake to m_tvalid.
  - There is a 1-cycle IDLE bubble between packets, so the next header needs IDLE -> HDR -> load.
- Boundary conditions
  - cfg_len changes mid-packet: no effect until the next IDLE exit.
  - cfg_len = 1: packet is header + one word with tlast.
  - Input bubbles (s_tvalid low in PAY): output drains, no tlast, counter unchanged.
  - m_tready held low: s_tready = 0 once the slot is full; no words are lost or duplicated.
  - seq and pkt_count wrap silently.
  - s_tready is combinational from state, m_tvalid and m_tready; there is no combinational path from s_tvalid to s_tready.

Test Plan:
- cfg_len = 4, continuous s_tvalid, m_tready = 1, s_tdata = 1,2,3,... -> output 16'hA000, 1, 2, 3, 4 (tlast on 4); then 16'hA001, 5, 6, 7, 8 (tlast on 8); pkt_count = 2.
- cfg_len = 0 -> each packet is header + 1 word; tlast on every payload word; header seq increments per packet.
- m_tready toggling randomly 50%, cfg_len = 7, 20 packets -> payload sequence intact, exactly one tlast per 8 output words, m_tdata stable while stalled, pkt_count = 20.
- cfg_len changed 4 -> 2 during the second payload word of a packet -> that packet still carries 4 payload words; the next packet carries 2.
- rst_n pulsed low asynchronously after the 2nd payload word of a 4-word packet -> m_tvalid = 0 and busy = 0 immediately; the next packet header is 16'hA000 and pkt_count = 0.
- Force seq to 4095 (4095 completed packets, cfg_len = 1) -> next header = 16'hAFFF, the following header = 16'hA000; pkt_count continues counting to 4097.
